pulse_measure: RTL and testbench

- Receive-side counterpart of the pulse extender in the BER datapath.
- Watches a level input for active pulses (active = DIN != RV) and measures each pulse's width in clock cycles.
- When a pulse ends, emits a one-cycle VALID strobe with the width, a saturation flag and a running pulse count.
- Used on the BER checker side to recover error-event lengths from stretched error indications.

---
 rtl/pulse_measure_if.sv | 41 ++++
 rtl/pulse_measure.sv | 137 +++++++++++++
 tb/tb_pulse_measure.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_measure_if.sv
// Pulse-measurement bus: monitored level, counter clear and per-pulse results.
// The MINW/DROP pair exists only when PULSE_MEASURE_MINW_EN is defined.
`timescale 1ns/1ps

interface pulse_measure_if #(
  parameter int CBW = 8,
  parameter int PBW = 16
);
  logic           DIN;
  logic           CNT_CLR;
  logic           VALID;
  logic [CBW-1:0] WIDTH;
  logic           OVF;
  logic           BUSY;
  logic [PBW-1:0] PCNT;
  logic           PSAT;
`ifdef PULSE_MEASURE_MINW_EN
  logic [CBW-1:0] MINW;
  logic           DROP;

  modport master (
    input  DIN, CNT_CLR, MINW,
    output VALID, WIDTH, OVF, BUSY, PCNT, PSAT, DROP
  );

  modport slave (
    output DIN, CNT_CLR, MINW,
    input  VALID, WIDTH, OVF, BUSY, PCNT, PSAT, DROP
  );
`else
  modport master (
    input  DIN, CNT_CLR,
    output VALID, WIDTH, OVF, BUSY, PCNT, PSAT
  );

  modport slave (
    output DIN, CNT_CLR,
    input  VALID, WIDTH, OVF, BUSY, PCNT, PSAT
  );
`endif
endinterface

// File: rtl/pulse_measure.sv
// Measures the width of each DIN pulse (DIN != RV) and reports it on pulse end.
// Optional minimum-width filter enabled by defining PULSE_MEASURE_MINW_EN.
//
//   state | meaning
//   IDLE  | d1 at rest level, waiting for a pulse
//   MEAS  | pulse in progress, cnt = active samples seen so far
`timescale 1ns/1ps

module pulse_measure #(
  parameter int   CBW = 8,
  parameter int   PBW = 16,
  parameter logic RV  = 1'b0
) (
  input logic            CLK,
  input logic            RST,
  pulse_measure_if.master bus
);

  localparam logic [0:0]     ST_IDLE = 1'b0;
  localparam logic [0:0]     ST_MEAS = 1'b1;
  localparam logic [CBW-1:0] CNT_MAX = '1;
  localparam logic [CBW-1:0] CNT_ONE = {{(CBW-1){1'b0}}, 1'b1};
  localparam logic [PBW-1:0] PCNT_MAX = '1;

  logic           d1;
  logic [0:0]     state;
  logic [CBW-1:0] cnt;
  logic           sat;

  logic           valid_q;
  logic [CBW-1:0] width_q;
  logic           ovf_q;
  logic [PBW-1:0] pcnt_q;
  logic           psat_q;
`ifdef PULSE_MEASURE_MINW_EN
  logic           drop_q;
`endif

  logic active;
  logic pulse_end;
  logic accept;

  always_comb begin
    active    = (d1 != RV);
    pulse_end = (state == ST_MEAS) && !active;
`ifdef PULSE_MEASURE_MINW_EN
    accept    = (cnt >= bus.MINW);
`else
    accept    = 1'b1;
`endif
  end

  // Input register plus measuring FSM; cnt holds at all-ones and flags sat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      d1    <= RV;
      state <= ST_IDLE;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      d1 <= bus.DIN;
      case (state)
        ST_IDLE: begin
          if (active) begin
            state <= ST_MEAS;
            cnt   <= CNT_ONE;
            sat   <= 1'b0;
          end
        end
        ST_MEAS: begin
          if (active) begin
            if (cnt == CNT_MAX) begin
              sat <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= 1'b0;
      width_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= pulse_end && accept;
      if (pulse_end && accept) begin
        width_q <= cnt;
        ovf_q   <= sat;
      end
    end
  end

`ifdef PULSE_MEASURE_MINW_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= pulse_end && !accept;
    end
  end
`endif

  // A clear in the same cycle as a pulse end wins over the increment.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pcnt_q <= '0;
      psat_q <= 1'b0;
    end else if (bus.CNT_CLR) begin
      pcnt_q <= '0;
      psat_q <= 1'b0;
    end else if (pulse_end && accept) begin
      if (pcnt_q == PCNT_MAX) begin
        psat_q <= 1'b1;
      end else begin
        pcnt_q <= pcnt_q + {{(PBW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.VALID = valid_q;
  assign bus.WIDTH = width_q;
  assign bus.OVF   = ovf_q;
  assign bus.BUSY  = (state == ST_MEAS);
  assign bus.PCNT  = pcnt_q;
  assign bus.PSAT  = psat_q;
`ifdef PULSE_MEASURE_MINW_EN
  assign bus.DROP  = drop_q;
`endif

endmodule

// File: tb/tb_pulse_measure.sv
// Bench for pulse_measure: RV=0 and RV=1 instances driven with mirrored DIN,
// checked every cycle against a run-length model of the pulse stream.
`timescale 1ns/1ps

module tb_pulse_measure;

  localparam int CBW  = 4;
  localparam int PBW  = 4;
  localparam int WMAX = (1 << CBW) - 1;
  localparam int PMAX = (1 << PBW) - 1;
  localparam int MAXL = 1024;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  pulse_measure_if #(.CBW(CBW), .PBW(PBW)) bus0 ();
  pulse_measure_if #(.CBW(CBW), .PBW(PBW)) bus1 ();

  pulse_measure #(.CBW(CBW), .PBW(PBW), .RV(1'b0)) dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0.master)
  );

  pulse_measure #(.CBW(CBW), .PBW(PBW), .RV(1'b1)) dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus1.master)
  );

  typedef struct packed {
    logic           valid;
    logic           busy;
    logic [CBW-1:0] width;
    logic           ovf;
    logic [PBW-1:0] pcnt;
    logic           psat;
    logic           drop;
  } obs_t;

  int n_checks = 0;
  int n_pass   = 0;

  bit din_q[$];
  bit clr_q[$];

  int m_w     = 0;
  bit m_ovf   = 1'b0;
  int m_pcnt  = 0;
  bit m_psat  = 1'b0;
  int m_minw  = 0;

`ifdef PULSE_MEASURE_MINW_EN
  assign bus0.MINW = m_minw[CBW-1:0];
  assign bus1.MINW = m_minw[CBW-1:0];
`endif

  function automatic obs_t get_obs(input int di);
    obs_t o;
    o = '0;
    if (di == 0) begin
      o.valid = bus0.VALID; o.busy = bus0.BUSY; o.width = bus0.WIDTH;
      o.ovf = bus0.OVF; o.pcnt = bus0.PCNT; o.psat = bus0.PSAT;
`ifdef PULSE_MEASURE_MINW_EN
      o.drop = bus0.DROP;
`endif
    end else begin
      o.valid = bus1.VALID; o.busy = bus1.BUSY; o.width = bus1.WIDTH;
      o.ovf = bus1.OVF; o.pcnt = bus1.PCNT; o.psat = bus1.PSAT;
`ifdef PULSE_MEASURE_MINW_EN
      o.drop = bus1.DROP;
`endif
    end
    return o;
  endfunction

  function automatic obs_t model_obs(input bit valid, input bit busy, input bit drop);
    obs_t e;
    e = '0;
    e.valid = valid;
    e.busy  = busy;
    e.width = m_w[CBW-1:0];
    e.ovf   = m_ovf;
    e.pcnt  = m_pcnt[PBW-1:0];
    e.psat  = m_psat;
    e.drop  = drop;
    return e;
  endfunction

  // dut1 sees the inverted level so both rest polarities get the same stimulus.
  task automatic drive(input bit d, input bit c, input bit r);
    bus0.DIN     = d;
    bus1.DIN     = ~d;
    bus0.CNT_CLR = c;
    bus1.CNT_CLR = c;
    RST          = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic add_pulse(input int n, input int gap);
    for (int i = 0; i < n; i++) begin din_q.push_back(1'b1); clr_q.push_back(1'b0); end
    for (int i = 0; i < gap; i++) begin din_q.push_back(1'b0); clr_q.push_back(1'b0); end
  endtask

  task automatic seq_end();
    for (int i = 0; i < 3; i++) begin din_q.push_back(1'b0); clr_q.push_back(1'b0); end
  endtask

  // Pulses are found as runs of active samples; a run starting at sample s of
  // length n keeps BUSY high after edges s+1..s+n and reports after edge s+n+1.
  task automatic run_seq(input string tag);
    int   len;
    int   k;
    int   s;
    int   n;
    int   cw;
    bit   endm [MAXL];
    int   endn [MAXL];
    bit   busy [MAXL];
    bit   ev;
    bit   ed;
    obs_t e;
    obs_t o;
    len = din_q.size();
    for (int i = 0; i < MAXL; i++) begin endm[i] = 1'b0; endn[i] = 0; busy[i] = 1'b0; end
    k = 0;
    while (k < len) begin
      if (din_q[k]) begin
        s = k;
        n = 0;
        while (k < len && din_q[k]) begin n++; k++; end
        for (int j = s + 1; j <= s + n && j < len; j++) busy[j] = 1'b1;
        if (s + n + 1 < len) begin endm[s+n+1] = 1'b1; endn[s+n+1] = n; end
      end else begin
        k++;
      end
    end
    for (int i = 0; i < len; i++) begin
      drive(din_q[i], clr_q[i], 1'b0);
      ev = 1'b0;
      ed = 1'b0;
      if (endm[i]) begin
        cw = (endn[i] > WMAX) ? WMAX : endn[i];
        if (cw >= m_minw) begin
          ev    = 1'b1;
          m_w   = cw;
          m_ovf = (endn[i] > WMAX);
          if (!clr_q[i]) begin
            if (m_pcnt == PMAX) m_psat = 1'b1;
            else m_pcnt++;
          end
        end else begin
          ed = 1'b1;
        end
      end
      if (clr_q[i]) begin m_pcnt = 0; m_psat = 1'b0; end
      e = model_obs(ev, busy[i], ed);
      for (int di = 0; di < 2; di++) begin
        o = get_obs(di);
        n_checks++;
        if (o !== e)
          $display("FAIL %s dut%0d step %0d: got v%0b b%0b w%0d o%0b pc%0d ps%0b dr%0b, exp v%0b b%0b w%0d o%0b pc%0d ps%0b dr%0b",
                   tag, di, i, o.valid, o.busy, o.width, o.ovf, o.pcnt, o.psat, o.drop,
                   e.valid, e.busy, e.width, e.ovf, e.pcnt, e.psat, e.drop);
        else
          n_pass++;
      end
    end
    din_q.delete();
    clr_q.delete();
  endtask

  task automatic test_reset();
    obs_t o;
    obs_t e;
    m_w = 0; m_ovf = 1'b0; m_pcnt = 0; m_psat = 1'b0;
    e = model_obs(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, 1'b0, i < 3);
      for (int di = 0; di < 2; di++) begin
        o = get_obs(di);
        n_checks++;
        if (o !== e)
          $display("FAIL reset dut%0d step %0d: got %h exp %h", di, i, o, e);
        else
          n_pass++;
      end
    end
  endtask

  task automatic test_single();
    add_pulse(1, 1);
    seq_end();
    run_seq("single");
  endtask

  task automatic test_back_to_back();
    add_pulse(3, 1);
    add_pulse(5, 1);
    add_pulse(1, 1);
    add_pulse(2, 1);
    seq_end();
    run_seq("b2b");
  endtask

  task automatic test_saturation();
    add_pulse(15, 2);
    add_pulse(20, 2);
    add_pulse(16, 1);
    add_pulse(14, 2);
    add_pulse(40, 2);
    seq_end();
    run_seq("sat");
  endtask

  task automatic test_pcnt_sat();
    int st;
    for (int i = 0; i < 17; i++) add_pulse(1, 1);
    seq_end();
    run_seq("pcnt17");
    n_checks++;
    if (bus0.PCNT !== 4'd15 || bus0.PSAT !== 1'b1)
      $display("FAIL pcnt_stop: got pcnt %0d psat %0b, exp pcnt 15 psat 1", bus0.PCNT, bus0.PSAT);
    else
      n_pass++;
    st = din_q.size();
    add_pulse(2, 3);
    clr_q[st + 3] = 1'b1;
    seq_end();
    run_seq("clr_coinc");
    n_checks++;
    if (bus1.PCNT !== 4'd0 || bus1.PSAT !== 1'b0 || bus1.WIDTH !== 4'd2)
      $display("FAIL clr_coinc_end: got pcnt %0d psat %0b w %0d, exp pcnt 0 psat 0 w 2",
               bus1.PCNT, bus1.PSAT, bus1.WIDTH);
    else
      n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    bit [10:0] dv;
    bit [10:0] rv;
    bit [10:0] bv;
    obs_t o;
    obs_t e;
    dv = 11'b000_1111_1111;
    rv = 11'b000_0001_0000;
    bv = 11'b001_1100_1110;
    for (int i = 0; i < 11; i++) begin
      drive(dv[i], 1'b0, rv[i]);
      if (rv[i]) begin m_w = 0; m_ovf = 1'b0; m_pcnt = 0; m_psat = 1'b0; end
      if (i == 9) begin m_w = 3; m_pcnt = 1; end
      e = model_obs(i == 9, bv[i], 1'b0);
      for (int di = 0; di < 2; di++) begin
        o = get_obs(di);
        n_checks++;
        if (o !== e)
          $display("FAIL rst_mid dut%0d step %0d: got v%0b b%0b w%0d pc%0d, exp v%0b b%0b w%0d pc%0d",
                   di, i, o.valid, o.busy, o.width, o.pcnt, e.valid, e.busy, e.width, e.pcnt);
        else
          n_pass++;
      end
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 25; p++)
      add_pulse($urandom_range(1, 20), $urandom_range(1, 4));
    seq_end();
    for (int i = 0; i < clr_q.size(); i++)
      clr_q[i] = ($urandom_range(0, 19) == 0);
    run_seq("random");
  endtask

`ifdef PULSE_MEASURE_MINW_EN
  task automatic test_minw();
    int pc0;
    m_minw = 3;
    pc0 = m_pcnt;
    add_pulse(2, 2);
    add_pulse(3, 2);
    seq_end();
    run_seq("minw3");
    n_checks++;
    if (bus0.PCNT !== 4'(pc0 + 1) || bus0.WIDTH !== 4'd3)
      $display("FAIL minw3_end: got pcnt %0d w %0d, exp pcnt %0d w 3", bus0.PCNT, bus0.WIDTH, pc0 + 1);
    else
      n_pass++;
    m_minw = 1;
    add_pulse(1, 1);
    add_pulse(1, 1);
    seq_end();
    run_seq("minw1");
    m_minw = $urandom_range(2, 12);
    for (int p = 0; p < 12; p++)
      add_pulse($urandom_range(1, 18), $urandom_range(1, 3));
    seq_end();
    run_seq("minw_rand");
    m_minw = 0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.DIN = 1'b0; bus1.DIN = 1'b1;
    bus0.CNT_CLR = 1'b0; bus1.CNT_CLR = 1'b0;
    RST = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_pcnt_sat();
    test_reset_mid_pulse();
    test_random();
`ifdef PULSE_MEASURE_MINW_EN
    test_minw();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
